// File: rtl/mcu_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_spi_pkg
//  Description : Shared types and constants for the MCU SPI raw sensor packet
//                (16-byte frame: header, quaternion w/x/y/z, gyro x/y/z, flags).
//  Revision    : 1.0 - initial release
// ============================================================================
package mcu_spi_pkg;

    localparam int         PACKET_SIZE = 16;
    localparam int         PACKET_BITS = PACKET_SIZE * 8;
    localparam logic [7:0] HEADER_BYTE = 8'hAA;

    // Byte offsets within the frame; multi-byte fields are big-endian pairs.
    localparam int OFF_HDR   = 0;
    localparam int OFF_QW    = 1;
    localparam int OFF_QX    = 3;
    localparam int OFF_QY    = 5;
    localparam int OFF_QZ    = 7;
    localparam int OFF_GX    = 9;
    localparam int OFF_GY    = 11;
    localparam int OFF_GZ    = 13;
    localparam int OFF_FLAGS = 15;

    typedef struct packed {
        logic signed [15:0] quat_w;
        logic signed [15:0] quat_x;
        logic signed [15:0] quat_y;
        logic signed [15:0] quat_z;
        logic signed [15:0] gyro_x;
        logic signed [15:0] gyro_y;
        logic signed [15:0] gyro_z;
        logic               quat_valid;
        logic               gyro_valid;
    } imu_raw_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACK    = 3'd1,
        ST_SCK_LO = 3'd2,
        ST_SCK_HI = 3'd3,
        ST_CHECK  = 3'd4
    } state_t;

    // Bit index of the MSB of byte 'off' in a frame shifted in MSB-first.
    function automatic int byte_msb(input int off);
        return PACKET_BITS - 1 - 8 * off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single-bit level crossing into clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give metastability a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/mcu_spi_master_rx.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_spi_master_rx
//  Description : SPI mode-0 master that acknowledges the slave's done, clocks
//                in a 128-bit raw IMU packet MSB-first, checks the header and
//                presents the decoded sample on parallel outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcu_spi_master_rx
    import mcu_spi_pkg::*;
#(
    parameter int         CLK_DIV = 4,
    parameter logic [7:0] HEADER  = HEADER_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               done,
    output logic               load,
    output logic               sck,
    output logic               sdo,
    input  logic               sdi,
    output logic signed [15:0] quat_w,
    output logic signed [15:0] quat_x,
    output logic signed [15:0] quat_y,
    output logic signed [15:0] quat_z,
    output logic signed [15:0] gyro_x,
    output logic signed [15:0] gyro_y,
    output logic signed [15:0] gyro_z,
    output logic               quat_valid,
    output logic               gyro_valid,
    output logic               pkt_valid,
    output logic               hdr_err,
    output logic               busy
);

    localparam int               CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [7:0]       BIT_LAST = 8'(PACKET_BITS);

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [7:0]             bit_cnt_q;
    logic [PACKET_BITS-1:0] shreg_q;
    imu_raw_t               raw_q;
    imu_raw_t               raw_d;
    logic                   pkt_valid_q;
    logic                   hdr_err_q;
    logic                   done_prev_q;
    logic                   done_s;
    logic                   trigger;

    sync_2ff u_sync_done (
        .clk (clk),
        .rst (rst),
        .d_i (done),
        .q_o (done_s)
    );

    assign trigger = done_s & ~done_prev_q;

    // Field decode of the received frame, ready to commit when the header matches.
    always_comb begin
        raw_d            = '0;
        raw_d.quat_w     = shreg_q[byte_msb(OFF_QW) -: 16];
        raw_d.quat_x     = shreg_q[byte_msb(OFF_QX) -: 16];
        raw_d.quat_y     = shreg_q[byte_msb(OFF_QY) -: 16];
        raw_d.quat_z     = shreg_q[byte_msb(OFF_QZ) -: 16];
        raw_d.gyro_x     = shreg_q[byte_msb(OFF_GX) -: 16];
        raw_d.gyro_y     = shreg_q[byte_msb(OFF_GY) -: 16];
        raw_d.gyro_z     = shreg_q[byte_msb(OFF_GZ) -: 16];
        raw_d.quat_valid = shreg_q[byte_msb(OFF_FLAGS) - 7];
        raw_d.gyro_valid = shreg_q[byte_msb(OFF_FLAGS) - 6];
    end

    // Transfer sequencer: ack, 128 sck periods, header check, back to idle.
    // The header verdict is registered on the last SCK_HI edge so that the
    // strobes and new outputs are visible during the CHECK cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            raw_q       <= '0;
            pkt_valid_q <= 1'b0;
            hdr_err_q   <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            done_prev_q <= done_s;
            pkt_valid_q <= 1'b0;
            hdr_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        state_q   <= ST_ACK;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                ST_ACK: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        state_q <= ST_SCK_LO;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SCK_LO: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        state_q <= ST_SCK_HI;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SCK_HI: begin
                    if (cnt_q == '0) begin
                        shreg_q   <= {shreg_q[PACKET_BITS-2:0], sdi};
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                    end
                    if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= ST_CHECK;
                            if (shreg_q[byte_msb(OFF_HDR) -: 8] == HEADER) begin
                                raw_q       <= raw_d;
                                pkt_valid_q <= 1'b1;
                            end else begin
                                hdr_err_q <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_SCK_LO;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign load       = (state_q == ST_ACK);
    assign sck        = (state_q == ST_SCK_HI);
    assign busy       = (state_q != ST_IDLE);
    assign sdo        = 1'b0;
    assign pkt_valid  = pkt_valid_q;
    assign hdr_err    = hdr_err_q;
    assign quat_w     = raw_q.quat_w;
    assign quat_x     = raw_q.quat_x;
    assign quat_y     = raw_q.quat_y;
    assign quat_z     = raw_q.quat_z;
    assign gyro_x     = raw_q.gyro_x;
    assign gyro_y     = raw_q.gyro_y;
    assign gyro_z     = raw_q.gyro_z;
    assign quat_valid = raw_q.quat_valid;
    assign gyro_valid = raw_q.gyro_valid;

endmodule
`default_nettype wire

// File: tb/tb_mcu_spi_master_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcu_spi_master_rx
//  Description : Bench for mcu_spi_master_rx. Two instances (CLK_DIV 4 and 2)
//                each talk to a mode-0 slave model; a cycle-window model of
//                the transfer predicts every output on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_spi_master_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  done_v, load_v, sck_v, sdo_v, sdi_v, qv_v, gv_v, pv_v, he_v, busy_v;
    logic [15:0] qw_v [2], qx_v [2], qy_v [2], qz_v [2], gx_v [2], gy_v [2], gz_v [2];

    always #5 clk = ~clk;

    mcu_spi_master_rx #(.CLK_DIV(4), .HEADER(8'hAA)) u_dut0 (
        .clk(clk), .rst(rst), .done(done_v[0]), .load(load_v[0]), .sck(sck_v[0]),
        .sdo(sdo_v[0]), .sdi(sdi_v[0]), .quat_w(qw_v[0]), .quat_x(qx_v[0]),
        .quat_y(qy_v[0]), .quat_z(qz_v[0]), .gyro_x(gx_v[0]), .gyro_y(gy_v[0]),
        .gyro_z(gz_v[0]), .quat_valid(qv_v[0]), .gyro_valid(gv_v[0]),
        .pkt_valid(pv_v[0]), .hdr_err(he_v[0]), .busy(busy_v[0]));

    mcu_spi_master_rx #(.CLK_DIV(2), .HEADER(8'hAA)) u_dut1 (
        .clk(clk), .rst(rst), .done(done_v[1]), .load(load_v[1]), .sck(sck_v[1]),
        .sdo(sdo_v[1]), .sdi(sdi_v[1]), .quat_w(qw_v[1]), .quat_x(qx_v[1]),
        .quat_y(qy_v[1]), .quat_z(qz_v[1]), .gyro_x(gx_v[1]), .gyro_y(gy_v[1]),
        .gyro_z(gz_v[1]), .quat_valid(qv_v[1]), .gyro_valid(gv_v[1]),
        .pkt_valid(pv_v[1]), .hdr_err(he_v[1]), .busy(busy_v[1]));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic int dv(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 50)
                $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
        end
    endtask

    // ---------------- slave model (mode 0, data changes on falling sck) -----
    logic [7:0] next_b [2][16];
    logic [7:0] sb     [2][16];
    int         sidx   [2];
    logic       s_sck_p[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (load_v[i]) begin
                for (int k = 0; k < 16; k++) sb[i][k] = next_b[i][k];
                sidx[i] = 0;
            end else if (s_sck_p[i] && !sck_v[i] && sidx[i] < 127) begin
                sidx[i] = sidx[i] + 1;
            end
            s_sck_p[i] = sck_v[i];
            sdi_v[i]   = sb[i][sidx[i] / 8][7 - (sidx[i] % 8)];
        end
    end

    // ---------------- reference model --------------------------------------
    // st = first ACK cycle of the current/last transfer (-1: none since reset).
    int          st     [2];
    bit          trig_p [2], h1 [2], h2 [2];
    bit          e_load [2], e_sck [2], e_busy [2], e_pv [2], e_he [2];
    logic [15:0] m_qw [2], m_qx [2], m_qy [2], m_qz [2], m_gx [2], m_gy [2], m_gz [2];
    bit          m_qv [2], m_gv [2];
    int          md, mc, mo;

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            md = dv(i);
            if (rst) begin
                st[i] = -1; trig_p[i] = 0; h1[i] = 0; h2[i] = 0;
                m_qw[i] = 0; m_qx[i] = 0; m_qy[i] = 0; m_qz[i] = 0;
                m_gx[i] = 0; m_gy[i] = 0; m_gz[i] = 0; m_qv[i] = 0; m_gv[i] = 0;
            end else begin
                // A trigger seen in the previous cycle starts a transfer only if idle then.
                if (trig_p[i] && (st[i] < 0 || cyc - 1 > st[i] + md + 256 * md))
                    st[i] = cyc;
                trig_p[i] = h1[i] & ~h2[i];
                h2[i] = h1[i];
                h1[i] = done_v[i];
            end
            mc = st[i] + md + 256 * md;
            mo = cyc - (st[i] + md);
            e_load[i] = (st[i] >= 0) && cyc >= st[i] && cyc < st[i] + md;
            e_sck[i]  = (st[i] >= 0) && mo >= 0 && mo < 256 * md && ((mo / md) % 2 == 1);
            e_busy[i] = (st[i] >= 0) && cyc <= mc;
            e_pv[i]   = (st[i] >= 0) && cyc == mc && sb[i][0] == 8'hAA;
            e_he[i]   = (st[i] >= 0) && cyc == mc && sb[i][0] != 8'hAA;
            if (e_pv[i]) begin
                m_qw[i] = {sb[i][1],  sb[i][2]};
                m_qx[i] = {sb[i][3],  sb[i][4]};
                m_qy[i] = {sb[i][5],  sb[i][6]};
                m_qz[i] = {sb[i][7],  sb[i][8]};
                m_gx[i] = {sb[i][9],  sb[i][10]};
                m_gy[i] = {sb[i][11], sb[i][12]};
                m_gz[i] = {sb[i][13], sb[i][14]};
                m_qv[i] = sb[i][15][0];
                m_gv[i] = sb[i][15][1];
            end
        end
    end

    // ---------------- per-cycle compare ------------------------------------
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                chk("load",      i, 16'(load_v[i]), 16'(e_load[i]));
                chk("sck",       i, 16'(sck_v[i]),  16'(e_sck[i]));
                chk("busy",      i, 16'(busy_v[i]), 16'(e_busy[i]));
                chk("pkt_valid", i, 16'(pv_v[i]),   16'(e_pv[i]));
                chk("hdr_err",   i, 16'(he_v[i]),   16'(e_he[i]));
                chk("sdo",       i, 16'(sdo_v[i]),  16'd0);
                chk("quat_w",    i, qw_v[i], m_qw[i]);
                chk("quat_x",    i, qx_v[i], m_qx[i]);
                chk("quat_y",    i, qy_v[i], m_qy[i]);
                chk("quat_z",    i, qz_v[i], m_qz[i]);
                chk("gyro_x",    i, gx_v[i], m_gx[i]);
                chk("gyro_y",    i, gy_v[i], m_gy[i]);
                chk("gyro_z",    i, gz_v[i], m_gz[i]);
                chk("quat_valid",i, 16'(qv_v[i]), 16'(m_qv[i]));
                chk("gyro_valid",i, 16'(gv_v[i]), 16'(m_gv[i]));
            end
        end
    end

    // ---------------- event counters ---------------------------------------
    int load_cnt [2], sck_rise [2], pv_cnt [2], he_cnt [2], load_start [2], pv_cyc [2];
    logic mon_load_p [2], mon_sck_p [2];

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (load_v[i] && !mon_load_p[i]) load_start[i] = cyc;
            if (load_v[i]) load_cnt[i]++;
            if (sck_v[i] && !mon_sck_p[i]) sck_rise[i]++;
            if (pv_v[i]) begin pv_cnt[i]++; pv_cyc[i] = cyc; end
            if (he_v[i]) he_cnt[i]++;
            mon_load_p[i] = load_v[i];
            mon_sck_p[i]  = sck_v[i];
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic set_pkt(input int i, input logic [127:0] p);
        for (int k = 0; k < 16; k++) next_b[i][k] = p[127 - 8 * k -: 8];
    endtask

    function automatic logic [127:0] rand_pkt(input bit hdr_ok);
        logic [127:0] p;
        for (int k = 0; k < 4; k++) p[32 * k +: 32] = $urandom;
        if (hdr_ok) p[127:120] = 8'hAA;
        else if (p[127:120] == 8'hAA) p[127:120] = 8'h00;
        return p;
    endfunction

    // Waits for the end of a transfer (either strobe), bounded.
    task automatic wait_end(input int i, input int maxc);
        int base;
        int k;
        base = pv_cnt[i] + he_cnt[i];
        k = 0;
        while (pv_cnt[i] + he_cnt[i] == base && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("xfer_end_timeout", i, 16'(pv_cnt[i] + he_cnt[i] != base), 16'd1);
    endtask

    task automatic rand_xfer(input int i);
        repeat ($urandom_range(0, 20)) @(negedge clk);
        done_v[i] = 1'b1;
        wait_end(i, 1300);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        done_v[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    // ---------------- main sequence ----------------------------------------
    initial begin
        logic [127:0] p;
        int b_load, b_sck, b_pv, b_he, k;
        for (int i = 0; i < 2; i++) begin
            sidx[i] = 0; s_sck_p[i] = 0; mon_load_p[i] = 0; mon_sck_p[i] = 0;
            load_cnt[i] = 0; sck_rise[i] = 0; pv_cnt[i] = 0; he_cnt[i] = 0;
            load_start[i] = 0; pv_cyc[i] = 0; st[i] = -1;
            for (int j = 0; j < 16; j++) begin sb[i][j] = 8'h00; next_b[i][j] = 8'h00; end
        end
        rst = 1'b1;
        done_v = 2'b00;
        sdi_v = 2'b00;
        repeat (4) @(negedge clk);
        chk("rst_load", 0, 16'(load_v[0]), 16'd0);
        chk("rst_sck",  0, 16'(sck_v[0]),  16'd0);
        chk("rst_busy", 0, 16'(busy_v[0]), 16'd0);
        chk("rst_qw",   0, qw_v[0],        16'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reference packet on both instances; flags differ on the fast one.
        set_pkt(0, 128'hAA12_34FF_FE00_0180_007F_FF00_10FF_F003);
        set_pkt(1, 128'hAA12_34FF_FE00_0180_007F_FF00_10FF_F002);
        done_v = 2'b11;
        fork
            wait_end(0, 1200);
            wait_end(1, 700);
        join
        chk("latency_div4", 0, 16'(pv_cyc[0] - load_start[0]), 16'd1028);
        chk("latency_div2", 1, 16'(pv_cyc[1] - load_start[1]), 16'd514);
        chk("lit_qw", 0, qw_v[0], 16'h1234);
        chk("lit_qx", 0, qx_v[0], 16'hFFFE);
        chk("lit_qy", 0, qy_v[0], 16'h0001);
        chk("lit_qz", 0, qz_v[0], 16'h8000);
        chk("lit_gx", 0, gx_v[0], 16'h7FFF);
        chk("lit_gy", 0, gy_v[0], 16'h0010);
        chk("lit_gz", 0, gz_v[0], 16'hFFF0);
        chk("lit_qv", 0, 16'(qv_v[0]), 16'd1);
        chk("lit_gv", 0, 16'(gv_v[0]), 16'd1);
        chk("lit_qv", 1, 16'(qv_v[1]), 16'd0);
        chk("lit_gv", 1, 16'(gv_v[1]), 16'd1);
        chk("load_cycles", 0, 16'(load_cnt[0]), 16'd4);
        chk("sck_rises",   0, 16'(sck_rise[0]), 16'd128);
        repeat (2) @(negedge clk);
        done_v = 2'b00;
        repeat (5) @(negedge clk);

        // Bad header: error strobe, outputs held.
        set_pkt(0, 128'h5512_34FF_FE00_0180_007F_FF00_10FF_F003);
        b_pv = pv_cnt[0]; b_he = he_cnt[0];
        done_v[0] = 1'b1;
        wait_end(0, 1200);
        repeat (2) @(negedge clk);
        done_v[0] = 1'b0;
        chk("hdr_err_count", 0, 16'(he_cnt[0] - b_he), 16'd1);
        chk("hdr_no_pv",     0, 16'(pv_cnt[0] - b_pv), 16'd0);
        chk("hdr_hold_qw",   0, qw_v[0], 16'h1234);
        repeat (5) @(negedge clk);

        // done held high for 5000 cycles: exactly one transfer.
        set_pkt(0, rand_pkt(1'b1));
        b_load = load_cnt[0]; b_sck = sck_rise[0]; b_pv = pv_cnt[0];
        done_v[0] = 1'b1;
        repeat (5000) @(negedge clk);
        done_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_load", 0, 16'(load_cnt[0] - b_load), 16'd4);
        chk("hold_sck",  0, 16'(sck_rise[0] - b_sck),  16'd128);
        chk("hold_pv",   0, 16'(pv_cnt[0] - b_pv),     16'd1);

        // Reset in the middle of the frame, then a clean transfer.
        set_pkt(0, rand_pkt(1'b1));
        b_sck = sck_rise[0];
        done_v[0] = 1'b1;
        k = 0;
        while (sck_rise[0] - b_sck < 60 && k < 2000) begin @(negedge clk); k++; end
        chk("reach_bit60", 0, 16'(sck_rise[0] - b_sck), 16'd60);
        rst = 1'b1;
        done_v[0] = 1'b0;
        @(negedge clk);
        chk("mid_rst_sck",  0, 16'(sck_v[0]),  16'd0);
        chk("mid_rst_load", 0, 16'(load_v[0]), 16'd0);
        chk("mid_rst_busy", 0, 16'(busy_v[0]), 16'd0);
        chk("mid_rst_qw",   0, qw_v[0],        16'd0);
        rst = 1'b0;
        p = rand_pkt(1'b1);
        set_pkt(0, p);
        repeat (3) @(negedge clk);
        done_v[0] = 1'b1;
        wait_end(0, 1200);
        chk("post_rst_qw", 0, qw_v[0], p[119:104]);
        chk("post_rst_gz", 0, gz_v[0], p[23:8]);
        chk("post_rst_qv", 0, 16'(qv_v[0]), 16'(p[0]));
        done_v[0] = 1'b0;
        repeat (5) @(negedge clk);

        // done re-pulsed during SCK_HI of an active transfer.
        set_pkt(0, rand_pkt(1'b1));
        b_load = load_cnt[0]; b_sck = sck_rise[0]; b_pv = pv_cnt[0]; b_he = he_cnt[0];
        done_v[0] = 1'b1;
        repeat (10) @(negedge clk);
        done_v[0] = 1'b0;
        k = 0;
        while (!(sck_v[0] && sck_rise[0] - b_sck >= 20) && k < 2000) begin @(negedge clk); k++; end
        done_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        done_v[0] = 1'b0;
        wait_end(0, 1200);
        repeat (1100) @(negedge clk);
        chk("repulse_pv",   0, 16'(pv_cnt[0] - b_pv),     16'd1);
        chk("repulse_he",   0, 16'(he_cnt[0] - b_he),     16'd0);
        chk("repulse_load", 0, 16'(load_cnt[0] - b_load), 16'd4);

        // Randomized packets on both instances, some with bad headers.
        for (int r = 0; r < 6; r++) begin
            set_pkt(0, rand_pkt($urandom_range(0, 3) != 0));
            set_pkt(1, rand_pkt($urandom_range(0, 3) != 0));
            fork
                rand_xfer(0);
                rand_xfer(1);
            join
            repeat (4) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
